// File: rtl/segment_transition_ctl.sv
// Read-segment sequencer for the modulation/STM sampler: owns the sample index,
// counts loop repetitions and swaps the active segment on the selected trigger.
module segment_transition_ctl #(
    parameter int CycleWidth   = 16,
    parameter int RepWidth     = 16,
    parameter int SysTimeWidth = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    UPDATE,
    input  logic                    REQ_SEGMENT,
    input  logic [7:0]              TRANSITION_MODE,
    input  logic [SysTimeWidth-1:0] TRANSITION_VALUE,
    input  logic [CycleWidth-1:0]   CYCLE0,
    input  logic [CycleWidth-1:0]   CYCLE1,
    input  logic [RepWidth-1:0]     REP0,
    input  logic [RepWidth-1:0]     REP1,
    input  logic                    TICK,
    input  logic [SysTimeWidth-1:0] SYS_TIME,
    input  logic [3:0]              GPIO_IN,
    output logic                    SEGMENT,
    output logic [CycleWidth-1:0]   IDX,
    output logic                    STOP,
    output logic                    PENDING,
    output logic                    SWAP,
    output logic                    ERR
);

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_WAIT_IDX  = 3'd1;
    localparam logic [2:0] ST_WAIT_TIME = 3'd2;
    localparam logic [2:0] ST_WAIT_GPIO = 3'd3;
    localparam logic [2:0] ST_EXT_RUN   = 3'd4;

    localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME = 8'h01;
    localparam logic [7:0] MODE_GPIO     = 8'h02;
    localparam logic [7:0] MODE_EXT      = 8'hF0;

    logic [2:0]              state_q, state_d;
    logic                    seg_q, seg_d;
    logic [CycleWidth-1:0]   idx_q, idx_d;
    logic [RepWidth-1:0]     loop_q, loop_d;
    logic                    stop_q, stop_d;
    logic                    pending_q, pending_d;
    logic                    swap_q, swap_d;
    logic                    err_q, err_d;
    logic                    inf_q, inf_d;
    logic                    ext_q, ext_d;
    logic                    req_seg_q, req_seg_d;
    logic [SysTimeWidth-1:0] tval_q, tval_d;
    logic [3:0]              gs1_q, gs2_q, gs3_q;

    logic [CycleWidth-1:0]   cycle_cur;
    logic [RepWidth-1:0]     rep_cur;
    logic [RepWidth-1:0]     rep_req;
    logic [RepWidth-1:0]     rep_other;
    logic                    wrap;
    logic                    rep_done;
    logic                    gpio_rise;
    logic                    fire;

    always_comb begin
        cycle_cur = seg_q ? CYCLE1 : CYCLE0;
        rep_cur   = seg_q ? REP1 : REP0;
        rep_other = seg_q ? REP0 : REP1;
        rep_req   = req_seg_q ? REP1 : REP0;
        // >= rather than == so an index left beyond a shrunken CYCLE wraps on the next tick
        wrap      = (idx_q >= cycle_cur);
        rep_done  = !inf_q && (rep_cur != '1) && (loop_q >= rep_cur);
        gpio_rise = gs2_q[tval_q[1:0]] & ~gs3_q[tval_q[1:0]];

        case (state_q)
            ST_WAIT_IDX:  fire = TICK && (wrap || stop_q);
            ST_WAIT_TIME: fire = (SYS_TIME >= tval_q);
            ST_WAIT_GPIO: fire = gpio_rise;
            default:      fire = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        idx_d     = idx_q;
        loop_d    = loop_q;
        stop_d    = stop_q;
        pending_d = pending_q;
        swap_d    = 1'b0;
        err_d     = err_q;
        inf_d     = inf_q;
        ext_d     = ext_q;
        req_seg_d = req_seg_q;
        tval_d    = tval_q;

        if (fire) begin
            seg_d     = req_seg_q;
            idx_d     = '0;
            loop_d    = '0;
            stop_d    = 1'b0;
            inf_d     = (rep_req == '1);
            swap_d    = 1'b1;
            pending_d = 1'b0;
            state_d   = ext_q ? ST_EXT_RUN : ST_RUN;
        end else if (TICK && !stop_q) begin
            if (!wrap) begin
                idx_d = idx_q + 1'b1;
            end else if (!rep_done) begin
                idx_d  = '0;
                loop_d = loop_q + 1'b1;
            end else if (state_q == ST_EXT_RUN) begin
                // Auto-swap replaces STOP: re-arm repetition from the other segment
                seg_d  = ~seg_q;
                idx_d  = '0;
                loop_d = '0;
                inf_d  = (rep_other == '1);
                swap_d = 1'b1;
            end else begin
                idx_d  = cycle_cur;
                stop_d = 1'b1;
            end
        end

        if (UPDATE) begin
            case (TRANSITION_MODE)
                MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT: begin
                    pending_d = 1'b1;
                    err_d     = 1'b0;
                    req_seg_d = REQ_SEGMENT;
                    tval_d    = TRANSITION_VALUE;
                    ext_d     = (TRANSITION_MODE == MODE_EXT);
                    case (TRANSITION_MODE)
                        MODE_SYS_TIME: state_d = ST_WAIT_TIME;
                        MODE_GPIO:     state_d = ST_WAIT_GPIO;
                        default:       state_d = ST_WAIT_IDX;
                    endcase
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            seg_q     <= 1'b0;
            idx_q     <= '0;
            loop_q    <= '0;
            stop_q    <= 1'b0;
            pending_q <= 1'b0;
            swap_q    <= 1'b0;
            err_q     <= 1'b0;
            inf_q     <= 1'b1;
            ext_q     <= 1'b0;
            req_seg_q <= 1'b0;
            tval_q    <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            idx_q     <= idx_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
            pending_q <= pending_d;
            swap_q    <= swap_d;
            err_q     <= err_d;
            inf_q     <= inf_d;
            ext_q     <= ext_d;
            req_seg_q <= req_seg_d;
            tval_q    <= tval_d;
        end
    end

    // Two-stage synchronizer plus edge-detect stage for the GPIO pads
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gs1_q <= '0;
            gs2_q <= '0;
            gs3_q <= '0;
        end else begin
            gs1_q <= GPIO_IN;
            gs2_q <= gs1_q;
            gs3_q <= gs2_q;
        end
    end

    assign SEGMENT = seg_q;
    assign IDX     = idx_q;
    assign STOP    = stop_q;
    assign PENDING = pending_q;
    assign SWAP    = swap_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed self-checking bench for segment_transition_ctl.
module tb_segment_transition_ctl;

    logic        clk;
    logic        rst;
    logic        update;
    logic        req_segment;
    logic [7:0]  transition_mode;
    logic [63:0] transition_value;
    logic [15:0] cycle0, cycle1;
    logic [15:0] rep0, rep1;
    logic        tick;
    logic [63:0] sys_time;
    logic [3:0]  gpio_in;
    logic        segment;
    logic [15:0] idx;
    logic        stop;
    logic        pending;
    logic        swap;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_seg;
    logic seen_swap;
    logic seen_stop;

    segment_transition_ctl #(
        .CycleWidth  (16),
        .RepWidth    (16),
        .SysTimeWidth(64)
    ) dut (
        .CLK             (clk),
        .RST             (rst),
        .UPDATE          (update),
        .REQ_SEGMENT     (req_segment),
        .TRANSITION_MODE (transition_mode),
        .TRANSITION_VALUE(transition_value),
        .CYCLE0          (cycle0),
        .CYCLE1          (cycle1),
        .REP0            (rep0),
        .REP1            (rep1),
        .TICK            (tick),
        .SYS_TIME        (sys_time),
        .GPIO_IN         (gpio_in),
        .SEGMENT         (segment),
        .IDX             (idx),
        .STOP            (stop),
        .PENDING         (pending),
        .SWAP            (swap),
        .ERR             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_update(input logic seg, input logic [7:0] mode, input logic [63:0] val);
        update           = 1'b1;
        req_segment      = seg;
        transition_mode  = mode;
        transition_value = val;
        step();
        update = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_seg"},  64'(segment), 64'(0));
        check({tag, "_idx"},  64'(idx),     64'(0));
        check({tag, "_stop"}, 64'(stop),    64'(0));
        check({tag, "_pend"}, 64'(pending), 64'(0));
        check({tag, "_swap"}, 64'(swap),    64'(0));
        check({tag, "_err"},  64'(err),     64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; update = 1'b0; req_segment = 1'b0; transition_mode = 8'h00;
        transition_value = '0; cycle0 = 16'd3; cycle1 = 16'd4; rep0 = 16'hFFFF;
        rep1 = 16'd1; tick = 1'b0; sys_time = 64'd1000; gpio_in = 4'h0;
        exp_seg = 1'b0;

        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Free-running infinite loop over CYCLE0=3
        seen_swap = 1'b0;
        seen_stop = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            do_tick();
            check("loop_idx", 64'(idx), 64'(i % 4));
            seen_swap |= swap;
            seen_stop |= stop;
        end
        check("loop_no_swap", 64'(seen_swap), 64'(0));
        check("loop_no_stop", 64'(seen_stop), 64'(0));
        for (int i = 0; i < 3; i++) do_tick();
        check("pre_sync_idx", 64'(idx), 64'(1));

        // SYNC_IDX transition to finite segment 1
        do_update(1'b1, 8'h00, 64'd0);
        check("sync_pend0", 64'(pending), 64'(1));
        check("sync_seg0",  64'(segment), 64'(0));
        do_tick();
        check("sync_idx2",  64'(idx), 64'(2));
        do_tick();
        check("sync_idx3",  64'(idx), 64'(3));
        check("sync_pend3", 64'(pending), 64'(1));
        check("sync_swap3", 64'(swap), 64'(0));
        do_tick();
        check("sync_seg",   64'(segment), 64'(1));
        check("sync_idx",   64'(idx), 64'(0));
        check("sync_swap",  64'(swap), 64'(1));
        check("sync_pend",  64'(pending), 64'(0));
        step();
        check("sync_swap_pulse", 64'(swap), 64'(0));
        for (int i = 1; i <= 9; i++) do_tick();
        check("rep_idx9",  64'(idx), 64'(4));
        check("rep_stop9", 64'(stop), 64'(0));
        do_tick();
        check("rep_stop",  64'(stop), 64'(1));
        check("rep_hold",  64'(idx), 64'(4));
        do_tick();
        check("rep_hold2", 64'(idx), 64'(4));

        // SYS_TIME target in the future, out of STOP
        sys_time = 64'd1000;
        do_update(1'b0, 8'h01, 64'd1005);
        check("time_pend", 64'(pending), 64'(1));
        for (int t = 1001; t <= 1005; t++) begin
            sys_time = 64'(t);
            step();
            check("time_swap", 64'(swap), 64'(t == 1005));
        end
        check("time_seg",  64'(segment), 64'(0));
        check("time_stop", 64'(stop), 64'(0));
        check("time_idx",  64'(idx), 64'(0));

        // SYS_TIME target already passed fires one cycle after UPDATE
        do_update(1'b1, 8'h01, 64'd500);
        check("past_swap0", 64'(swap), 64'(0));
        check("past_pend0", 64'(pending), 64'(1));
        step();
        check("past_swap1", 64'(swap), 64'(1));
        check("past_seg",   64'(segment), 64'(1));

        // GPIO pin 2 selected; pin 1 must be ignored
        do_update(1'b0, 8'h02, 64'd2);
        gpio_in = 4'b0010;
        seen_swap = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); seen_swap |= swap; end
        gpio_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin step(); seen_swap |= swap; end
        check("gpio_wrong_pin", 64'(seen_swap), 64'(0));
        check("gpio_pend", 64'(pending), 64'(1));
        gpio_in = 4'b0100;
        step();
        check("gpio_lat1", 64'(swap), 64'(0));
        step();
        check("gpio_lat2", 64'(swap), 64'(0));
        step();
        check("gpio_lat3", 64'(swap), 64'(1));
        check("gpio_seg",  64'(segment), 64'(0));
        gpio_in = 4'b0000;

        // EXT auto-swap ping-pong
        cycle0 = 16'd1; cycle1 = 16'd1; rep0 = 16'd0; rep1 = 16'd0;
        do_update(1'b1, 8'hF0, 64'd0);
        do_tick();
        check("ext_pre_idx", 64'(idx), 64'(1));
        check("ext_pre_seg", 64'(segment), 64'(0));
        do_tick();
        check("ext_enter_seg",  64'(segment), 64'(1));
        check("ext_enter_swap", 64'(swap), 64'(1));
        exp_seg = 1'b1;
        seen_stop = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            if (k % 2 == 0) exp_seg = ~exp_seg;
            check("ext_seg",  64'(segment), 64'(exp_seg));
            check("ext_idx",  64'(idx), 64'((k % 2 == 1) ? 1 : 0));
            check("ext_swap", 64'(swap), 64'(k % 2 == 0));
            seen_stop |= stop;
        end
        check("ext_no_stop", 64'(seen_stop), 64'(0));

        // Unsupported mode: sticky ERR, alternation unaffected
        do_update(1'b0, 8'h33, 64'd0);
        check("bad_err",  64'(err), 64'(1));
        check("bad_pend", 64'(pending), 64'(0));
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            if (k % 2 == 0) exp_seg = ~exp_seg;
            check("bad_seg", 64'(segment), 64'(exp_seg));
            check("bad_err_sticky", 64'(err), 64'(1));
        end

        // Reset while pending in WAIT_TIME discards the request
        sys_time = 64'd1500;
        do_update(1'b1, 8'h01, 64'd2000);
        check("rst_err_clr", 64'(err), 64'(0));
        check("rst_pend",    64'(pending), 64'(1));
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        rst = 1'b0;
        sys_time = 64'd2500;
        seen_swap = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); seen_swap |= swap; end
        check("rst_no_swap", 64'(seen_swap), 64'(0));
        check("rst_pend_after", 64'(pending), 64'(0));
        check("rst_seg_after",  64'(segment), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
